// File: rtl/fetch_queue_if.sv
// Bundle of the fetch unit's two handshakes: the instruction memory port and
// the valid/ready instruction stream towards decode. The fetch unit uses the
// master view and the memory/decode side uses the slave view.
interface fetch_queue_if #(
   parameter int XLEN = 32
);
   logic            mem_valid;
   logic            mem_fence;
   logic            mem_instr;
   logic [XLEN-1:0] mem_addr;
   logic            mem_ready;
   logic [XLEN-1:0] mem_rdata;
   logic            y_valid;
   logic            y_ready;
   logic [XLEN-1:0] y_pc;
   logic [XLEN-1:0] y_instr;

   modport master (
      output mem_valid, mem_fence, mem_instr, mem_addr,
      input  mem_ready, mem_rdata,
      output y_valid, y_pc, y_instr,
      input  y_ready
   );

   modport slave (
      input  mem_valid, mem_fence, mem_instr, mem_addr,
      output mem_ready, mem_rdata,
      input  y_valid, y_pc, y_instr,
      output y_ready
   );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch unit with a circular prefetch queue of 16-bit parcels.
// One memory request is outstanding at a time; returned words are split into
// parcels, and the head of the queue is decoded into a 16-bit compressed or
// 32-bit instruction, which may straddle two memory words. Trap, mret, jump
// and fence redirect the stream, flushing the queue and dropping any stale
// response that is still in flight.
module fetch_queue #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 8,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            trap,
   input  logic [XLEN-1:0] mtvec,
   input  logic            mret,
   input  logic [XLEN-1:0] mepc,
   input  logic            jump,
   input  logic [XLEN-1:0] jump_addr,
   input  logic            fence,
   fetch_queue_if.master   bus
);

   localparam int AW = $clog2(DEPTH);

   typedef logic [AW-1:0] ptr_t;
   typedef logic [AW:0]   cnt_t;

   localparam ptr_t            PTR_ONE   = ptr_t'(1);
   localparam cnt_t            ISSUE_MAX = cnt_t'(DEPTH - 2);
   localparam logic [XLEN-1:0] HALF_MASK = {{(XLEN-1){1'b1}}, 1'b0};
   localparam logic [XLEN-1:0] WORD_MASK = {{(XLEN-2){1'b1}}, 2'b00};

   // Queue storage and bookkeeping
   logic [15:0]     parcels [DEPTH];
   ptr_t            rp;
   ptr_t            wp;
   cnt_t            count;
   logic [XLEN-1:0] hpc;
   logic [XLEN-1:0] faddr;
   logic            pending;
   logic            discard;
   logic            skip;
   logic            fence_pend;

   // Registered memory request outputs
   logic            mem_valid_q;
   logic            mem_fence_q;
   logic [XLEN-1:0] mem_addr_q;

   // Per-cycle decisions
   logic            redirect;
   logic [XLEN-1:0] target;
   logic [15:0]     p0;
   logic [15:0]     p1;
   logic            is_long;
   logic            head_valid;
   logic            pop;
   logic            resp;
   logic            push;
   logic            issue;
   cnt_t            push_cnt;
   cnt_t            pop_cnt;
   logic [XLEN-1:0] pop_bytes;

   // Redirect target selection, head decode, and the push/pop/issue decisions
   always_comb begin
      redirect = trap | mret | jump | fence;

      if (trap) begin
         target = mtvec;
      end else if (mret) begin
         target = mepc;
      end else begin
         target = jump_addr;
      end

      p0      = parcels[rp];
      p1      = parcels[rp + PTR_ONE];
      is_long = (p0[1:0] == 2'b11);

      head_valid = ~redirect & (is_long ? (count >= cnt_t'(2)) : (count >= cnt_t'(1)));
      pop        = head_valid & bus.y_ready;
      pop_cnt    = pop ? (is_long ? cnt_t'(2) : cnt_t'(1)) : cnt_t'(0);
      pop_bytes  = is_long ? XLEN'(4) : XLEN'(2);

      resp     = pending & bus.mem_ready;
      push     = resp & ~discard & ~redirect;
      push_cnt = push ? (skip ? cnt_t'(1) : cnt_t'(2)) : cnt_t'(0);

      // A full word must always fit, so stop asking once fewer than two slots remain
      issue = ~pending & ~redirect & (count <= ISSUE_MAX);
   end

   // Queue, request and redirect state; a redirect flushes the queue and wins over any pop
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            parcels[i] <= '0;
         end
         rp          <= '0;
         wp          <= '0;
         count       <= '0;
         hpc         <= RESET_PC;
         faddr       <= RESET_PC & WORD_MASK;
         pending     <= 1'b0;
         discard     <= 1'b0;
         skip        <= RESET_PC[1];
         fence_pend  <= 1'b0;
         mem_valid_q <= 1'b0;
         mem_fence_q <= 1'b0;
         mem_addr_q  <= RESET_PC & WORD_MASK;
      end else begin
         mem_valid_q <= issue;
         mem_fence_q <= issue & fence_pend;
         if (issue) begin
            mem_addr_q <= faddr;
         end

         if (resp) begin
            pending <= 1'b0;
         end else if (issue) begin
            pending <= 1'b1;
         end

         if (resp) begin
            discard <= 1'b0;
         end else if (redirect && pending) begin
            discard <= 1'b1;
         end

         if (push) begin
            if (skip) begin
               parcels[wp] <= bus.mem_rdata[31:16];
            end else begin
               parcels[wp]           <= bus.mem_rdata[15:0];
               parcels[wp + PTR_ONE] <= bus.mem_rdata[31:16];
            end
            wp <= wp + ptr_t'(push_cnt);
         end

         if (redirect) begin
            rp         <= wp;
            count      <= '0;
            hpc        <= target & HALF_MASK;
            faddr      <= target & WORD_MASK;
            skip       <= target[1];
            fence_pend <= fence;
         end else begin
            if (pop) begin
               rp  <= rp + ptr_t'(pop_cnt);
               hpc <= hpc + pop_bytes;
            end
            count <= count + push_cnt - pop_cnt;
            if (push) begin
               skip <= 1'b0;
            end
            if (issue) begin
               faddr      <= faddr + XLEN'(4);
               fence_pend <= 1'b0;
            end
         end
      end
   end

   assign bus.mem_valid = mem_valid_q;
   assign bus.mem_fence = mem_fence_q;
   assign bus.mem_instr = 1'b1;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.y_valid   = head_valid;
   assign bus.y_pc      = hpc;
   assign bus.y_instr   = is_long ? {p1, p0} : {16'h0000, p0};

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a behavioural instruction memory with
// configurable latency answers requests, a monitor logs every accepted
// instruction, and one task per scenario checks the logs against
// hand-computed values.
module tb_fetch_queue;

   localparam int XLEN  = 32;
   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        trap = 1'b0;
   logic        mret = 1'b0;
   logic        jump = 1'b0;
   logic        fence = 1'b0;
   logic [31:0] mtvec = '0;
   logic [31:0] mepc = '0;
   logic [31:0] jump_addr = '0;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int mem_lat = 1;
   int epoch = 0;
   int ob = 0;
   int rb = 0;
   int sb = 0;

   logic [31:0] mem [logic [31:0]];

   logic [31:0] out_pc[$];
   logic [31:0] out_instr[$];
   int          out_cyc[$];
   logic [31:0] req_addr[$];
   logic        req_fence[$];
   int          req_cyc[$];
   int          resp_cyc[$];

   fetch_queue_if #(.XLEN(XLEN)) bus ();

   fetch_queue #(
      .XLEN     (XLEN),
      .DEPTH    (DEPTH),
      .RESET_PC (32'h0)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .trap      (trap),
      .mtvec     (mtvec),
      .mret      (mret),
      .mepc      (mepc),
      .jump      (jump),
      .jump_addr (jump_addr),
      .fence     (fence),
      .bus       (bus)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Cycle counter used to timestamp requests, responses and accepted instructions
   always @(posedge clk) cyc <= cyc + 1;

   // Instruction memory: answers each request after mem_lat cycles unless a reset intervened
   initial begin
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         bus.mem_ready = 1'b0;
         if (rst && bus.mem_valid) begin
            logic [31:0] a;
            int          e;
            a = bus.mem_addr;
            e = epoch;
            req_addr.push_back(a);
            req_fence.push_back(bus.mem_fence);
            req_cyc.push_back(cyc);
            for (int i = 0; i < mem_lat; i++) @(posedge clk);
            #1;
            if (e == epoch && rst) begin
               bus.mem_ready = 1'b1;
               bus.mem_rdata = mem.exists(a) ? mem[a] : 32'h00000013;
               resp_cyc.push_back(cyc);
            end
         end
      end
   end

   // Monitor: log every instruction decode accepts
   initial begin
      forever begin
         @(negedge clk);
         if (rst && bus.y_valid && bus.y_ready) begin
            out_pc.push_back(bus.y_pc);
            out_instr.push_back(bus.y_instr);
            out_cyc.push_back(cyc);
         end
      end
   end

   task automatic run_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Hold reset long enough for any in-flight response wait to expire, then snapshot log bases
   task automatic do_reset(input int lat);
      rst         = 1'b0;
      trap        = 1'b0;
      mret        = 1'b0;
      jump        = 1'b0;
      fence       = 1'b0;
      bus.y_ready = 1'b0;
      epoch       = epoch + 1;
      mem_lat     = lat;
      mem.delete();
      run_cycles(6);
      ob = out_pc.size();
      rb = req_addr.size();
      sb = resp_cyc.size();
   endtask

   task automatic test_reset();
      do_reset(1);
      @(negedge clk);
      checks++; if (bus.mem_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_mem_valid got %b want 0", bus.mem_valid); end
      checks++; if (bus.mem_fence !== 1'b0) begin failures++; $display("[TB] FAIL reset_mem_fence got %b want 0", bus.mem_fence); end
      checks++; if (bus.mem_addr !== 32'h0) begin failures++; $display("[TB] FAIL reset_mem_addr got %h want 0", bus.mem_addr); end
      checks++; if (bus.mem_instr !== 1'b1) begin failures++; $display("[TB] FAIL reset_mem_instr got %b want 1", bus.mem_instr); end
      checks++; if (bus.y_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_y_valid got %b want 0", bus.y_valid); end
      checks++; if (bus.y_pc !== 32'h0) begin failures++; $display("[TB] FAIL reset_y_pc got %h want 0", bus.y_pc); end
      checks++; if (bus.y_instr !== 32'h0) begin failures++; $display("[TB] FAIL reset_y_instr got %h want 0", bus.y_instr); end
      @(posedge clk);
      #1;
      rst = 1'b1;
      bus.y_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checks++;
         if (bus.y_valid !== (c == 3)) begin failures++; $display("[TB] FAIL first_valid cycle %0d got %b want %b", c, bus.y_valid, (c == 3)); end
         if (c == 1) begin
            checks++;
            if (bus.mem_valid !== 1'b1 || bus.mem_addr !== 32'h0) begin failures++; $display("[TB] FAIL first_request got valid %b addr %h want 1 00000000", bus.mem_valid, bus.mem_addr); end
         end
         if (c == 3) begin
            checks++;
            if (bus.y_pc !== 32'h0 || bus.y_instr !== 32'h00000013) begin failures++; $display("[TB] FAIL first_instr got pc %h instr %h want 00000000 00000013", bus.y_pc, bus.y_instr); end
         end
      end
      run_cycles(12);
      checks++;
      if (out_pc.size() < ob + 2 || req_addr.size() < rb + 2) begin
         failures++; $display("[TB] FAIL addi_stream got %0d instrs %0d reqs want >=2 each", out_pc.size() - ob, req_addr.size() - rb);
      end else begin
         checks++; if (out_pc[ob+1] !== 32'h4 || out_instr[ob+1] !== 32'h00000013) begin failures++; $display("[TB] FAIL addi_second got pc %h instr %h want 00000004 00000013", out_pc[ob+1], out_instr[ob+1]); end
         checks++; if (req_addr[rb+1] !== 32'h4) begin failures++; $display("[TB] FAIL second_req_addr got %h want 00000004", req_addr[rb+1]); end
      end
   endtask

   task automatic test_compressed();
      logic [31:0] exp_pc [3];
      logic [31:0] exp_in [3];
      exp_pc = '{32'h0, 32'h2, 32'h4};
      exp_in = '{32'h00004501, 32'h00004501, 32'h00000013};
      do_reset(1);
      mem[32'h0] = 32'h45014501;
      mem[32'h4] = 32'h00000013;
      rst = 1'b1;
      bus.y_ready = 1'b1;
      run_cycles(15);
      checks++;
      if (out_pc.size() < ob + 3) begin
         failures++; $display("[TB] FAIL compressed_count got %0d want >=3", out_pc.size() - ob);
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_pc[ob+i] !== exp_pc[i] || out_instr[ob+i] !== exp_in[i]) begin
               failures++; $display("[TB] FAIL compressed_%0d got pc %h instr %h want %h %h", i, out_pc[ob+i], out_instr[ob+i], exp_pc[i], exp_in[i]);
            end
         end
      end
   endtask

   task automatic test_straddle();
      logic [31:0] exp_pc [3];
      logic [31:0] exp_in [3];
      exp_pc = '{32'h0, 32'h2, 32'h6};
      exp_in = '{32'h00004501, 32'h00000013, 32'h00004501};
      do_reset(1);
      mem[32'h0] = 32'h00134501;
      mem[32'h4] = 32'h45010000;
      rst = 1'b1;
      bus.y_ready = 1'b1;
      run_cycles(15);
      checks++;
      if (out_pc.size() < ob + 3 || resp_cyc.size() < sb + 2) begin
         failures++; $display("[TB] FAIL straddle_count got %0d instrs %0d resps want >=3 >=2", out_pc.size() - ob, resp_cyc.size() - sb);
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_pc[ob+i] !== exp_pc[i] || out_instr[ob+i] !== exp_in[i]) begin
               failures++; $display("[TB] FAIL straddle_%0d got pc %h instr %h want %h %h", i, out_pc[ob+i], out_instr[ob+i], exp_pc[i], exp_in[i]);
            end
         end
         checks++; if (out_cyc[ob] !== resp_cyc[sb] + 1) begin failures++; $display("[TB] FAIL resp_to_valid got cycle %0d want %0d", out_cyc[ob], resp_cyc[sb] + 1); end
         checks++; if (out_cyc[ob+1] !== resp_cyc[sb+1] + 1) begin failures++; $display("[TB] FAIL straddle_wait got cycle %0d want %0d", out_cyc[ob+1], resp_cyc[sb+1] + 1); end
      end
   endtask

   task automatic test_redirect_pending();
      bit seen;
      seen = 1'b0;
      do_reset(4);
      mem[32'h0]   = 32'h45014501;
      mem[32'h100] = 32'h45011111;
      mem[32'h104] = 32'h00000013;
      rst = 1'b1;
      bus.y_ready = 1'b1;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (bus.mem_valid) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         failures++; $display("[TB] FAIL redirect_first_req got none want request within 10 cycles");
      end else begin
         @(posedge clk);
         #1;
         jump = 1'b1;
         jump_addr = 32'h102;
         @(posedge clk);
         #1;
         jump = 1'b0;
         run_cycles(20);
         checks++;
         if (req_addr.size() < rb + 2 || out_pc.size() < ob + 2 || resp_cyc.size() < sb + 1) begin
            failures++; $display("[TB] FAIL redirect_count got %0d reqs %0d instrs want >=2 each", req_addr.size() - rb, out_pc.size() - ob);
         end else begin
            checks++; if (req_addr[rb+1] !== 32'h100) begin failures++; $display("[TB] FAIL redirect_addr got %h want 00000100", req_addr[rb+1]); end
            checks++; if (req_cyc[rb+1] <= resp_cyc[sb]) begin failures++; $display("[TB] FAIL redirect_wait got req cycle %0d want after %0d", req_cyc[rb+1], resp_cyc[sb]); end
            checks++; if (out_pc[ob] !== 32'h102 || out_instr[ob] !== 32'h00004501) begin failures++; $display("[TB] FAIL redirect_first got pc %h instr %h want 00000102 00004501", out_pc[ob], out_instr[ob]); end
            checks++; if (out_pc[ob+1] !== 32'h104 || out_instr[ob+1] !== 32'h00000013) begin failures++; $display("[TB] FAIL redirect_second got pc %h instr %h want 00000104 00000013", out_pc[ob+1], out_instr[ob+1]); end
         end
      end
   endtask

   task automatic test_priority();
      bit seen;
      int rc;
      int k;
      seen = 1'b0;
      do_reset(1);
      rst = 1'b1;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (bus.y_valid) seen = 1'b1;
      end
      checks++;
      if (!seen) begin failures++; $display("[TB] FAIL priority_fill got no valid want valid within 10 cycles"); end
      @(posedge clk);
      #1;
      trap = 1'b1; mtvec = 32'h80; jump = 1'b1; jump_addr = 32'h40; bus.y_ready = 1'b1;
      rc = cyc;
      @(negedge clk);
      checks++; if (bus.y_valid !== 1'b0) begin failures++; $display("[TB] FAIL redirect_masks_valid got %b want 0", bus.y_valid); end
      @(posedge clk);
      #1;
      trap = 1'b0; jump = 1'b0;
      run_cycles(12);
      k = -1;
      for (int i = rb; i < req_addr.size() && k < 0; i++) if (req_cyc[i] > rc) k = i;
      checks++;
      if (k < 0) begin failures++; $display("[TB] FAIL trap_req got none want 00000080"); end
      else if (req_addr[k] !== 32'h80 || req_fence[k] !== 1'b0) begin failures++; $display("[TB] FAIL trap_req got %h fence %b want 00000080 0", req_addr[k], req_fence[k]); end
      checks++;
      if (out_pc.size() <= ob) begin failures++; $display("[TB] FAIL trap_instr got none want pc 00000080"); end
      else if (out_pc[ob] !== 32'h80) begin failures++; $display("[TB] FAIL trap_instr got pc %h want 00000080", out_pc[ob]); end

      mret = 1'b1; mepc = 32'h300; jump = 1'b1; jump_addr = 32'h40;
      rc = cyc;
      @(posedge clk);
      #1;
      mret = 1'b0; jump = 1'b0;
      run_cycles(12);
      k = -1;
      for (int i = rb; i < req_addr.size() && k < 0; i++) if (req_cyc[i] > rc) k = i;
      checks++;
      if (k < 0) begin failures++; $display("[TB] FAIL mret_req got none want 00000300"); end
      else if (req_addr[k] !== 32'h300) begin failures++; $display("[TB] FAIL mret_req got %h want 00000300", req_addr[k]); end
      k = -1;
      for (int i = ob; i < out_pc.size() && k < 0; i++) if (out_cyc[i] > rc) k = i;
      checks++;
      if (k < 0) begin failures++; $display("[TB] FAIL mret_instr got none want pc 00000300"); end
      else if (out_pc[k] !== 32'h300) begin failures++; $display("[TB] FAIL mret_instr got pc %h want 00000300", out_pc[k]); end

      fence = 1'b1; jump_addr = 32'h200;
      rc = cyc;
      @(posedge clk);
      #1;
      fence = 1'b0;
      run_cycles(12);
      k = -1;
      for (int i = rb; i < req_addr.size() && k < 0; i++) if (req_cyc[i] > rc) k = i;
      checks++;
      if (k < 0 || k + 1 >= req_addr.size()) begin failures++; $display("[TB] FAIL fence_reqs got too few want two after fence"); end
      else begin
         if (req_addr[k] !== 32'h200 || req_fence[k] !== 1'b1) begin failures++; $display("[TB] FAIL fence_first got %h fence %b want 00000200 1", req_addr[k], req_fence[k]); end
         checks++;
         if (req_addr[k+1] !== 32'h204 || req_fence[k+1] !== 1'b0) begin failures++; $display("[TB] FAIL fence_next got %h fence %b want 00000204 0", req_addr[k+1], req_fence[k+1]); end
      end
   endtask

   task automatic test_back_to_back();
      int rc;
      int n;
      do_reset(1);
      rst = 1'b1;
      run_cycles(40);
      checks++; if (req_addr.size() - rb !== 4) begin failures++; $display("[TB] FAIL full_reqs got %0d want 4", req_addr.size() - rb); end
      @(negedge clk);
      checks++; if (bus.y_valid !== 1'b1 || bus.mem_valid !== 1'b0) begin failures++; $display("[TB] FAIL full_state got valid %b mem_valid %b want 1 0", bus.y_valid, bus.mem_valid); end
      @(posedge clk);
      #1;
      bus.y_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.y_ready = 1'b0;
      run_cycles(10);
      checks++; if (req_addr.size() - rb !== 5) begin failures++; $display("[TB] FAIL resume_reqs got %0d want 5", req_addr.size() - rb); end
      checks++; if (out_pc.size() - ob !== 1) begin failures++; $display("[TB] FAIL single_pop got %0d want 1", out_pc.size() - ob); end
      @(negedge clk);
      checks++; if (bus.y_pc !== 32'h4) begin failures++; $display("[TB] FAIL after_pop_pc got %h want 00000004", bus.y_pc); end

      @(posedge clk);
      #1;
      jump = 1'b1; jump_addr = 32'h2;
      rc = cyc;
      @(posedge clk);
      #1;
      jump = 1'b0;
      run_cycles(40);
      n = 0;
      for (int i = rb; i < req_addr.size(); i++) if (req_cyc[i] > rc) n++;
      checks++; if (n !== 4) begin failures++; $display("[TB] FAIL odd_fill_reqs got %0d want 4", n); end
      @(negedge clk);
      checks++; if (bus.y_pc !== 32'h2 || bus.y_instr !== 32'h0 || bus.y_valid !== 1'b1) begin failures++; $display("[TB] FAIL odd_fill_head got pc %h instr %h valid %b want 00000002 00000000 1", bus.y_pc, bus.y_instr, bus.y_valid); end
   endtask

   // Scenario sequence
   initial begin
      bus.y_ready = 1'b0;
      test_reset();
      test_compressed();
      test_straddle();
      test_redirect_pending();
      test_priority();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
